// File: rtl/prelude_loader_pkg.sv
// Shared types and constants for the Prelude program loader.
package prelude_loader_pkg;

    // Loader frame-parsing states
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        FINISH
    } loader_state_t;

    // Error codes reported on error_code while load_error is set
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Frame start byte
    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/prelude_prog_ram.sv
// 256x8 program RAM: synchronous write from the loader, asynchronous read for the core.
// No reset: contents survive resets and aborted frames.
module prelude_prog_ram (
    input  logic       clk,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [256];

    // Write port: one byte per clock when enabled
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prelude_prog_loader.sv
// Prelude program loader: parses MAGIC/LEN/DATA/CSUM frames from a valid/ready byte
// stream, writes the program RAM and keeps the core in reset until a frame passes.
//
// Handshake: a byte transfers on a rising clk edge where s_valid & s_ready are both 1.
// s_ready is registered; it is 1 in IDLE/LEN/DATA/CSUM, 0 in FINISH and in reset.
// s_valid may toggle at will; s_data is only looked at on a transfer.
module prelude_prog_loader
    import prelude_loader_pkg::*;
#(
    parameter logic [7:0] MAGIC          = DEFAULT_MAGIC,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic [7:0] cpu_address,
    output logic [7:0] cpu_data,
    output logic       cpu_reset,
    output logic       load_busy,
    output logic       load_done,
    output logic       load_error,
    output logic [1:0] error_code
);

    // Idle count at which the next idle cycle completes the timeout
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    loader_state_t state_q, state_d;
    logic [8:0]    count_q, count_d;   // bytes still to receive; 256 needs 9 bits
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    sum_q, sum_d;
    logic [15:0]   idle_q, idle_d;
    logic          pass_q, pass_d;
    logic          ready_q, ready_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic          xfer;
    logic          ram_we;
    logic [7:0]    csum_total;

    assign xfer       = s_valid & ready_q;
    assign csum_total = sum_q + s_data;

    // State and status registers; RAM is deliberately outside this reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            idle_q      <= '0;
            pass_q      <= 1'b0;
            ready_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            idle_q      <= idle_d;
            pass_q      <= pass_d;
            ready_q     <= ready_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    // Next-state, counters, checksum and status flags
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        idle_d      = idle_q;
        pass_d      = pass_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        err_d       = err_q;
        code_d      = code_q;
        ram_we      = 1'b0;

        // Inter-byte timeout inside a frame; only fires on a cycle without a transfer
        if (state_q inside {LEN, DATA, CSUM}) begin
            if (xfer) begin
                idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
                idle_d      = '0;
                state_d     = IDLE;
                err_d       = 1'b1;
                code_d      = ERR_TIMEOUT;
                cpu_reset_d = 1'b1;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (xfer && s_data == MAGIC) begin
                    state_d     = LEN;
                    idle_d      = '0;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    code_d      = ERR_NONE;
                end
            end
            LEN: begin
                if (xfer) begin
                    count_d = (s_data == 8'h00) ? 9'd256 : {1'b0, s_data};
                    addr_d  = '0;
                    sum_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    ram_we  = 1'b1;
                    addr_d  = addr_q + 8'd1;
                    sum_d   = csum_total;
                    count_d = count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    pass_d  = (csum_total == 8'h00);
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (pass_q) begin
                    done_d      = 1'b1;
                    cpu_reset_d = 1'b0;
                end else begin
                    err_d  = 1'b1;
                    code_d = ERR_CSUM;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != FINISH);
        busy_d  = (state_d != IDLE);
    end

    prelude_prog_ram u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (addr_q),
        .wdata_i (s_data),
        .raddr_i (cpu_address),
        .rdata_o (cpu_data)
    );

    assign s_ready    = ready_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_error = err_q;
    assign error_code = code_q;

endmodule

// File: tb/tb_prelude_prog_loader.sv
// Bench for prelude_prog_loader: directed frames, status scoreboard, RAM readback.
module tb_prelude_prog_loader;

    localparam int T = 255;

    logic       clk;
    logic       reset;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [7:0] cpu_address;
    logic [7:0] cpu_data;
    logic       cpu_reset;
    logic       load_busy;
    logic       load_done;
    logic       load_error;
    logic [1:0] error_code;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected status at each frame completion: {done, error, code, cpu_reset}
    logic [4:0] exp_q[$];

    prelude_prog_loader #(.MAGIC(8'hA5), .TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_reset   (cpu_reset),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_error  (load_error),
        .error_code  (error_code)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on each rise of done/error, pop the expected completion status
    logic prev_flag = 1'b0;
    always @(negedge clk) begin
        logic cur;
        logic [4:0] exp;
        cur = load_done | load_error;
        if (cur && !prev_flag) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", {load_done, load_error, error_code, cpu_reset}, 5'h0);
            end else begin
                exp = exp_q.pop_front();
                check("completion_status", {load_done, load_error, error_code, cpu_reset}, exp);
            end
        end
        prev_flag <= cur;
    end

    // Driver: present one byte from a negedge, hold until it transfers
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            check("s_ready_wait", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic send_frame1(input logic [7:0] csum);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hB1);
        send_byte(8'h8A);
        send_byte(8'h44);
        send_byte(csum);
    endtask

    task automatic check_mem(input logic [7:0] a, input logic [7:0] exp);
        cpu_address = a;
        #1;
        check($sformatf("mem[%0h]", a), cpu_data, exp);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        s_valid     = 1'b0;
        s_data      = 8'h00;
        cpu_address = 8'h00;

        // Reset values
        @(negedge clk);
        check("reset_state", {s_ready, cpu_reset, load_busy, load_done, load_error, error_code},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", s_ready, 1'b1);

        // Test 1: good frame, done exactly two edges after CSUM accept
        exp_q.push_back({1'b1, 1'b0, 2'b00, 1'b0});
        send_byte(8'hA5);
        @(negedge clk);
        check("t1_busy_after_magic", load_busy, 1'b1);
        send_byte(8'h03);
        send_byte(8'hB1);
        send_byte(8'h8A);
        send_byte(8'h44);
        send_byte(8'h81);
        @(negedge clk);
        check("t1_finish_edge1", {s_ready, load_done, cpu_reset, load_busy}, {1'b0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        check("t1_finish_edge2", {s_ready, load_done, cpu_reset, load_busy}, {1'b1, 1'b1, 1'b0, 1'b0});
        check_mem(8'h00, 8'hB1);
        check_mem(8'h01, 8'h8A);
        check_mem(8'h02, 8'h44);

        // Test 2: bad checksum
        exp_q.push_back({1'b0, 1'b1, 2'b01, 1'b1});
        send_frame1(8'h80);
        wait_edges(2);
        check("t2_status", {load_done, load_error, error_code, cpu_reset}, {1'b0, 1'b1, 2'b01, 1'b1});

        // Test 3: leading junk discarded, then good frame
        exp_q.push_back({1'b1, 1'b0, 2'b00, 1'b0});
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        @(negedge clk);
        check("t3_junk_ignored", {load_busy, load_error}, {1'b0, 1'b1});
        send_frame1(8'h81);
        wait_edges(2);
        check("t3_status", {load_done, load_error, cpu_reset}, {1'b1, 1'b0, 1'b0});
        check_mem(8'h01, 8'h8A);

        // Test 4: timeout exactly T cycles after the last accepted byte
        exp_q.push_back({1'b0, 1'b1, 2'b10, 1'b1});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (T - 1) @(posedge clk);
        @(negedge clk);
        check("t4_before_timeout", {load_error, load_busy}, {1'b0, 1'b1});
        @(posedge clk);
        @(negedge clk);
        check("t4_timeout", {load_error, error_code, cpu_reset, load_busy, s_ready},
              {1'b1, 2'b10, 1'b1, 1'b0, 1'b1});
        check_mem(8'h00, 8'h11);

        // Test 5: LEN=0 means 256 bytes
        exp_q.push_back({1'b1, 1'b0, 2'b00, 1'b0});
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int k = 0; k < 256; k++) begin
            send_byte(8'(k));
        end
        @(negedge clk);
        check("t5_still_busy_before_csum", load_busy, 1'b1);
        send_byte(8'h80);
        wait_edges(2);
        check("t5_status", {load_done, cpu_reset}, {1'b1, 1'b0});
        for (int k = 0; k < 256; k++) begin
            check_mem(8'(k), 8'(k));
        end

        // Test 6: async reset mid-DATA, then a fresh frame
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h77);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_reset_async", {s_ready, cpu_reset, load_busy, load_done, load_error, error_code},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
        check_mem(8'h00, 8'h77);
        check_mem(8'h01, 8'h01);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 2'b00, 1'b0});
        send_frame1(8'h81);
        wait_edges(2);
        check("t6_status", {load_done, load_error, cpu_reset}, {1'b1, 1'b0, 1'b0});
        check_mem(8'h00, 8'hB1);
        check_mem(8'h02, 8'h44);

        wait_edges(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
